mlp_train_sequencer: RTL and testbench

- Synthesizable-style driver for the MLP training/inference port. It produces `values`, `expected`, `training`, `learning_rate` and the activation selects, and consumes `prediction`.
- Replaces hand-written stimulus loops. Per epoch it runs one training pass over a truth-table dataset of 2**INPUTS samples, then one evaluation pass.
- Each epoch it reports a classification score; it stops after EPOCHS epochs, or early on a perfect score.

---
 rtl/mlp_train_sequencer_pkg.sv | 30 +++
 rtl/mlp_train_sequencer_truth_table_rom.sv | 18 +
 rtl/mlp_train_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types and constants for the MLP training sequencer: activation selects,
// sequencer state encoding, classification threshold and the BCE log guard.
package mlp_train_sequencer_pkg;

  typedef enum logic [1:0] {
    RELU    = 2'd0,
    SIGMOID = 2'd1,
    TANH    = 2'd2,
    LINEAR  = 2'd3
  } act_func;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_APPLY = 3'd1,
    T_HOLD  = 3'd2,
    E_APPLY = 3'd3,
    E_HOLD  = 3'd4,
    REPORT  = 3'd5,
    DONE    = 3'd6
  } seq_state_e;

  localparam real THRESHOLD = 0.5;
  localparam real epsilon   = 1.0e-7;

  // Values at or above the threshold classify as 1.
  function automatic logic class_of(input real x);
    return !(x < THRESHOLD);
  endfunction

endpackage

// File: rtl/mlp_train_sequencer_truth_table_rom.sv
// Combinational truth-table dataset: sample index k -> MLP input vector and target.
module truth_table_rom #(
  parameter int                      INPUTS = 2,
  parameter logic [(2**INPUTS)-1:0]  TRUTH  = 4'b0110
) (
  input  logic [INPUTS-1:0] k,
  output real               values [INPUTS-1:0],
  output real               expected
);

  always_comb begin
    for (int j = 0; j < INPUTS; j++) begin
      values[j] = k[j] ? 1.0 : 0.0;
    end
    expected = TRUTH[k] ? 1.0 : 0.0;
  end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Epoch sequencer driving an MLP through a training pass and an evaluation pass
// over a truth-table dataset. Define MLP_SEQ_COST_EN to add the per-epoch BCE `cost` output.
module mlp_train_sequencer
  import mlp_train_sequencer_pkg::*;
#(
  parameter int                      INPUTS      = 2,
  parameter logic [(2**INPUTS)-1:0]  TRUTH       = 4'b0110,
  parameter int                      EPOCHS      = 100,
  parameter int                      HOLD_CYCLES = 1,
  parameter real                     LR          = 0.1,
  parameter bit                      EARLY_STOP  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  real                         prediction [0:0],
  output real                         values [INPUTS-1:0],
  output real                         expected [0:0],
  output logic                        training,
  output real                         learning_rate,
  output act_func                     hidden_activation,
  output act_func                     output_activation,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 epoch,
  output logic [$clog2(2**INPUTS):0]  correct,
  output logic                        epoch_valid
`ifdef MLP_SEQ_COST_EN
  ,
  output real                         cost
`endif
);

  localparam int S     = 2**INPUTS;
  localparam int CW    = $clog2(S) + 1;
  localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [INPUTS-1:0] K_LAST    = INPUTS'(S - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_T_APPLY = T_APPLY;
  localparam logic [2:0] ST_T_HOLD  = T_HOLD;
  localparam logic [2:0] ST_E_APPLY = E_APPLY;
  localparam logic [2:0] ST_E_HOLD  = E_HOLD;
  localparam logic [2:0] ST_REPORT  = REPORT;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]        state;
  logic [INPUTS-1:0] k;
  logic [HW-1:0]     hold_cnt;
  logic [CW-1:0]     acc;
  logic              stim_on;
  logic              hit;
  logic              hold_last;
  logic              stop_now;
  real               rom_values [INPUTS-1:0];
  real               rom_expected;

  truth_table_rom #(
    .INPUTS (INPUTS),
    .TRUTH  (TRUTH)
  ) u_rom (
    .k        (k),
    .values   (rom_values),
    .expected (rom_expected)
  );

  assign learning_rate     = LR;
  assign hidden_activation = RELU;
  assign output_activation = SIGMOID;

  // Stimulus follows the registered index; zero until the first run after reset.
  always_comb begin
    for (int j = 0; j < INPUTS; j++) begin
      values[j] = stim_on ? rom_values[j] : 0.0;
    end
    expected[0] = stim_on ? rom_expected : 0.0;
  end

  assign hit       = (class_of(prediction[0]) == class_of(expected[0]));
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign stop_now  = ((epoch + 16'd1) == 16'(EPOCHS)) || (EARLY_STOP && (acc == CW'(S)));

`ifdef MLP_SEQ_COST_EN
  real cost_acc;
  real bce;

  always_comb begin
    bce = -(expected[0] * $ln(prediction[0] + epsilon)
          + (1.0 - expected[0]) * $ln(1.0 - prediction[0] + epsilon));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cost_acc <= 0.0;
      cost     <= 0.0;
    end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
      cost_acc <= 0.0;
    end else if (state == ST_E_HOLD && hold_last) begin
      cost_acc <= cost_acc + bce;
    end else if (state == ST_REPORT) begin
      cost     <= cost_acc;
      cost_acc <= 0.0;
    end
  end
`endif

  // NOTE: all state is non-blocking so every register samples pre-edge values;
  // the async reset branch must cover every register the run touches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      k           <= '0;
      hold_cnt    <= '0;
      acc         <= '0;
      stim_on     <= 1'b0;
      training    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      epoch       <= '0;
      correct     <= '0;
      epoch_valid <= 1'b0;
    end else begin
      epoch_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            epoch    <= '0;
            correct  <= '0;
            acc      <= '0;
            k        <= '0;
            hold_cnt <= '0;
            stim_on  <= 1'b1;
            training <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= ST_T_APPLY;
          end
        end
        ST_T_APPLY: begin
          hold_cnt <= '0;
          state    <= ST_T_HOLD;
        end
        ST_T_HOLD: begin
          if (hold_last) begin
            hold_cnt <= '0;
            if (k != K_LAST) begin
              k     <= k + INPUTS'(1);
              state <= ST_T_APPLY;
            end else begin
              k        <= '0;
              training <= 1'b0;
              state    <= ST_E_APPLY;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_E_APPLY: begin
          hold_cnt <= '0;
          state    <= ST_E_HOLD;
        end
        ST_E_HOLD: begin
          if (hold_last) begin
            hold_cnt <= '0;
            acc      <= acc + CW'(hit);
            if (k != K_LAST) begin
              k     <= k + INPUTS'(1);
              state <= ST_E_APPLY;
            end else begin
              state <= ST_REPORT;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_REPORT: begin
          correct     <= acc;
          epoch       <= epoch + 16'd1;
          epoch_valid <= 1'b1;
          acc         <= '0;
          if (stop_now) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            k        <= '0;
            training <= 1'b1;
            state    <= ST_T_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench: two sequencer instances (free-running and early-stop) driven by a
// stub MLP whose prediction is either ideal (0.9/0.1) or a constant 0.5.
module tb_mlp_train_sequencer;
  import mlp_train_sequencer_pkg::*;

  localparam int INPUTS = 2;
  localparam int CW     = $clog2(2**INPUTS) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic pred_mode = 1'b0;

  real pred_a [0:0];
  real pred_b [0:0];
  real values_a [INPUTS-1:0];
  real values_b [INPUTS-1:0];
  real exp_a [0:0];
  real exp_b [0:0];
  real lr_a, lr_b;
  act_func hid_a, hid_b, out_a, out_b;
  logic training_a, training_b, busy_a, busy_b, done_a, done_b, ev_a, ev_b;
  logic [15:0] epoch_a, epoch_b;
  logic [CW-1:0] correct_a, correct_b;
`ifdef MLP_SEQ_COST_EN
  real cost_a, cost_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    pred_a[0] = pred_mode ? 0.5 : ((exp_a[0] >= 0.5) ? 0.9 : 0.1);
    pred_b[0] = pred_mode ? 0.5 : ((exp_b[0] >= 0.5) ? 0.9 : 0.1);
  end

  mlp_train_sequencer #(
    .INPUTS(INPUTS), .TRUTH(4'b0110), .EPOCHS(3), .HOLD_CYCLES(3), .LR(0.1), .EARLY_STOP(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .prediction(pred_a), .values(values_a),
    .expected(exp_a), .training(training_a), .learning_rate(lr_a),
    .hidden_activation(hid_a), .output_activation(out_a), .busy(busy_a), .done(done_a),
    .epoch(epoch_a), .correct(correct_a), .epoch_valid(ev_a)
`ifdef MLP_SEQ_COST_EN
    , .cost(cost_a)
`endif
  );

  mlp_train_sequencer #(
    .INPUTS(INPUTS), .TRUTH(4'b0110), .EPOCHS(3), .HOLD_CYCLES(3), .LR(0.1), .EARLY_STOP(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .prediction(pred_b), .values(values_b),
    .expected(exp_b), .training(training_b), .learning_rate(lr_b),
    .hidden_activation(hid_b), .output_activation(out_b), .busy(busy_b), .done(done_b),
    .epoch(epoch_b), .correct(correct_b), .epoch_valid(ev_b)
`ifdef MLP_SEQ_COST_EN
    , .cost(cost_b)
`endif
  );

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
  endtask

  task automatic check_real(input string name, input real got, input real want, input real tol);
    n_checks++;
    if ((got - want) <= tol && (want - got) <= tol) n_pass++;
    else $display("FAIL %s: got %f, expected %f (t=%0t)", name, got, want, $time);
  endtask

  function automatic int vbits_a();
    return ((values_a[1] >= 0.5) ? 2 : 0) + ((values_a[0] >= 0.5) ? 1 : 0);
  endfunction

  function automatic int zero_stim_a();
    return (values_a[0] == 0.0 && values_a[1] == 0.0 && exp_a[0] == 0.0) ? 1 : 0;
  endfunction

  // Ends on a negedge with the start edge just behind it (cycle 0 = T_APPLY of sample 0).
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int cyc;
    int busy;
    int training;
    int ev;
    int epoch;
    int correct;
    int vbits;
    int ebit;
    int done;
    int b_done;
    int b_epoch;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    // cyc busy trn ev epoch correct vbits ebit done b_done b_epoch
    tbl[0]  = '{0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{4,   1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{12,  1, 1, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[3]  = '{15,  1, 1, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[4]  = '{16,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{20,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{31,  1, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[7]  = '{32,  1, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    tbl[8]  = '{33,  1, 1, 1, 1, 4, 0, 0, 0, 1, 1};
    tbl[9]  = '{34,  1, 1, 0, 1, 4, 0, 0, 0, 1, 1};
    tbl[10] = '{66,  1, 1, 1, 2, 4, 0, 0, 0, 1, 1};
    tbl[11] = '{99,  0, 0, 1, 3, 4, 3, 0, 1, 1, 1};
    tbl[12] = '{100, 0, 0, 0, 3, 4, 3, 0, 1, 1, 1};
    tbl[13] = '{110, 0, 0, 0, 3, 4, 3, 0, 1, 1, 1};

    // Reset held, then released with no start: everything stays at reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_zero_stim", zero_stim_a(), 1);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", int'(busy_a | done_a | training_a | ev_a), 0);
    end
    check("idle_epoch", int'(epoch_a), 0);
    check("idle_correct", int'(correct_a), 0);
    check("idle_zero_stim", zero_stim_a(), 1);
    check_real("learning_rate", lr_a, 0.1, 1.0e-12);
    check("hidden_act", int'(hid_a), int'(RELU));
    check("output_act", int'(out_a), int'(SIGMOID));

    // Run 1: ideal stub, table-driven timeline.
    pred_mode = 1'b0;
    pulse_start();
    begin
      int vi = 0;
      for (int c = 0; c <= 110; c++) begin
        if (c > 0) @(negedge clk);
        if (vi < NV && tbl[vi].cyc == c) begin
          check($sformatf("c%0d_busy", c), int'(busy_a), tbl[vi].busy);
          check($sformatf("c%0d_training", c), int'(training_a), tbl[vi].training);
          check($sformatf("c%0d_epoch_valid", c), int'(ev_a), tbl[vi].ev);
          check($sformatf("c%0d_epoch", c), int'(epoch_a), tbl[vi].epoch);
          check($sformatf("c%0d_correct", c), int'(correct_a), tbl[vi].correct);
          check($sformatf("c%0d_values", c), vbits_a(), tbl[vi].vbits);
          check($sformatf("c%0d_expected", c), (exp_a[0] >= 0.5) ? 1 : 0, tbl[vi].ebit);
          check($sformatf("c%0d_done", c), int'(done_a), tbl[vi].done);
          check($sformatf("c%0d_es_done", c), int'(done_b), tbl[vi].b_done);
          check($sformatf("c%0d_es_epoch", c), int'(epoch_b), tbl[vi].b_epoch);
          vi++;
        end
      end
    end
    check("es_correct", int'(correct_b), 4);

    // Run 2: restart from DONE with prediction 0.5; a start while busy is ignored.
    pred_mode = 1'b1;
    pulse_start();
    check("restart_done_clear", int'(done_a), 0);
    check("restart_busy", int'(busy_a), 1);
    check("restart_epoch", int'(epoch_a), 0);
    check("restart_correct", int'(correct_a), 0);
    check("restart_es_done", int'(done_b), 0);
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (c == 33) begin
        check("half_epoch_valid", int'(ev_a), 1);
        check("half_epoch", int'(epoch_a), 1);
        check("half_correct", int'(correct_a), 2);
        check("half_es_correct", int'(correct_b), 2);
        check("half_es_busy", int'(busy_b), 1);
`ifdef MLP_SEQ_COST_EN
        check_real("cost_half", cost_a, 2.0 * 2.0 * $ln(2.0), 1.0e-6);
`endif
      end
    end
    check("pre_reset_eval", int'(training_a), 0);
    check("pre_reset_epoch", int'(epoch_a), 1);

    // Reset mid E_HOLD of epoch 2 takes effect immediately.
    rst = 1'b0;
    #1;
    check("midrst_epoch", int'(epoch_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_zero_stim", zero_stim_a(), 1);
    check("midrst_training", int'(training_a), 0);
    check("midrst_correct", int'(correct_a), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", int'(busy_a), 0);
    pulse_start();
    check("rerun_epoch0", int'(epoch_a), 0);
    for (int c = 1; c <= 33; c++) @(negedge clk);
    check("rerun_epoch_valid", int'(ev_a), 1);
    check("rerun_epoch", int'(epoch_a), 1);
    check("rerun_correct", int'(correct_a), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
